padring_cfg_ctrl: RTL

PADRING_CFG_CTRL -- requirements
Module: padring_cfg_ctrl

---
 rtl/padring_cfg_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/padring_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// padring_cfg_ctrl
//
// Pad-ring configuration controller. A request port writes (and optionally
// reads) a per-pad shadow copy of cfg, tech_cfg and the {ie, oen} control
// bits. A commit sequence moves the shadow onto the live pad outputs safely:
//   OFF  : all pads forced to input-disabled / output-disabled for SETTLE cycles
//   LOAD : shadow cfg and tech_cfg copied to the live outputs in one cycle
//   ON   : SETTLE cycles for the new configuration to settle
//   then : ie/oen taken from the shadow and the FSM returns to IDLE
//
// Optional feature macro: PADRING_CFG_READBACK_EN
//   defined   -> reads return the shadow value, zero-extended to 16 bits
//   undefined -> reads return 0 (the response strobe and error flag still
//                behave normally); no read mux is built
//
// Ports
//   clk, nreset           clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE, never while
//                         commit is high)
//   req_write             1 = write, 0 = read
//   req_addr              pad index (>= NPADS is an error)
//   req_field             0 = cfg, 1 = tech_cfg, 2 = ctrl {ie, oen}, 3 = error
//   req_wdata             write data, LSB-aligned
//   rsp_valid             one-cycle strobe, one cycle after acceptance
//   rsp_err               bad address or field
//   rsp_rdata             read data
//   commit                start applying the shadow to the pads (IDLE only)
//   busy                  commit sequence in progress
//   pad_cfg               live cfg, pad i at [i*CFGW +: CFGW]
//   pad_tech_cfg          live tech_cfg, pad i at [i*TECHW +: TECHW]
//   pad_ie                live input enable
//   pad_oen               live output enable, active low
// -----------------------------------------------------------------------------
module padring_cfg_ctrl #(
  parameter int NPADS  = 36,
  parameter int CFGW   = 8,
  parameter int TECHW  = 16,
  parameter int AW     = 6,
  parameter int SETTLE = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AW-1:0]          req_addr,
  input  logic [1:0]             req_field,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [15:0]            rsp_rdata,
  input  logic                   commit,
  output logic                   busy,
  output logic [NPADS*CFGW-1:0]  pad_cfg,
  output logic [NPADS*TECHW-1:0] pad_tech_cfg,
  output logic [NPADS-1:0]       pad_ie,
  output logic [NPADS-1:0]       pad_oen
);

  // Counter holds values up to SETTLE.
  localparam int CNTW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OFF  = 2'd1,
    S_LOAD = 2'd2,
    S_ON   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [15:0]            rsp_rdata_q, rsp_rdata_d;

  logic [NPADS*CFGW-1:0]  sh_cfg_q, sh_cfg_d;
  logic [NPADS*TECHW-1:0] sh_tech_q, sh_tech_d;
  logic [NPADS-1:0]       sh_ie_q, sh_ie_d;
  logic [NPADS-1:0]       sh_oen_q, sh_oen_d;

  logic [NPADS*CFGW-1:0]  cfg_q, cfg_d;
  logic [NPADS*TECHW-1:0] tech_q, tech_d;
  logic [NPADS-1:0]       ie_q, ie_d;
  logic [NPADS-1:0]       oen_q, oen_d;

  logic                   cnt_last_s;
  logic                   addr_ok_s;
  logic                   bad_s;
  logic                   accept_s;
  logic [15:0]            rd_data_s;

  // One extra address bit so that NPADS == 2**AW still compares correctly.
  assign addr_ok_s  = ({1'b0, req_addr} < (AW+1)'(NPADS));
  assign bad_s      = ~addr_ok_s | (req_field == 2'd3);
  assign cnt_last_s = (cnt_q == CNTW'(SETTLE - 1));
  // ready_q already implies IDLE; commit wins over a same-cycle request.
  assign accept_s   = req_valid & ready_q & ~commit;

  // Sequencer next-state: IDLE -> OFF -> LOAD -> ON -> IDLE, counter restarts on every entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_OFF;
        end else begin
          state_d = S_IDLE;
        end
        cnt_d = '0;
      end
      S_OFF: begin
        if (cnt_last_s) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
        end
      end
      S_LOAD: begin
        state_d = S_ON;
        cnt_d   = '0;
      end
      S_ON: begin
        if (cnt_last_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // Live pad outputs: safe state on commit start, cfg/tech at LOAD entry, ie/oen on return to IDLE.
  always_comb begin
    cfg_d  = cfg_q;
    tech_d = tech_q;
    ie_d   = ie_q;
    oen_d  = oen_q;
    if ((state_q == S_IDLE) && commit) begin
      ie_d  = '0;
      oen_d = '1;
    end else if ((state_q == S_OFF) && cnt_last_s) begin
      cfg_d  = sh_cfg_q;
      tech_d = sh_tech_q;
    end else if ((state_q == S_ON) && cnt_last_s) begin
      ie_d  = sh_ie_q;
      oen_d = sh_oen_q;
    end else begin
      cfg_d = cfg_q;
    end
  end

`ifdef PADRING_CFG_READBACK_EN
  logic [CFGW-1:0]  sel_cfg_s;
  logic [TECHW-1:0] sel_tech_s;
  logic             sel_ie_s;
  logic             sel_oen_s;

  // Read mux: AND-OR select of the addressed pad, then field select and zero-extension.
  always_comb begin
    sel_cfg_s  = '0;
    sel_tech_s = '0;
    sel_ie_s   = 1'b0;
    sel_oen_s  = 1'b0;
    for (int i = 0; i < NPADS; i++) begin
      sel_cfg_s  = sel_cfg_s  | (sh_cfg_q[i*CFGW +: CFGW]    & {CFGW{req_addr == AW'(i)}});
      sel_tech_s = sel_tech_s | (sh_tech_q[i*TECHW +: TECHW] & {TECHW{req_addr == AW'(i)}});
      sel_ie_s   = sel_ie_s   | (sh_ie_q[i]  & (req_addr == AW'(i)));
      sel_oen_s  = sel_oen_s  | (sh_oen_q[i] & (req_addr == AW'(i)));
    end
    rd_data_s = 16'h0000;
    case (req_field)
      2'd0:    rd_data_s[CFGW-1:0]  = sel_cfg_s;
      2'd1:    rd_data_s[TECHW-1:0] = sel_tech_s;
      2'd2:    rd_data_s[1:0]       = {sel_ie_s, sel_oen_s};
      default: rd_data_s            = 16'h0000;
    endcase
  end
`else
  assign rd_data_s = 16'h0000;
`endif

  // Shadow writes and response formation for an accepted request.
  always_comb begin
    sh_cfg_d    = sh_cfg_q;
    sh_tech_d   = sh_tech_q;
    sh_ie_d     = sh_ie_q;
    sh_oen_d    = sh_oen_q;
    rsp_valid_d = accept_s;
    rsp_err_d   = accept_s & bad_s;
    rsp_rdata_d = (accept_s & ~req_write & ~bad_s) ? rd_data_s : 16'h0000;
    for (int i = 0; i < NPADS; i++) begin
      if (accept_s && req_write && !bad_s && (req_addr == AW'(i))) begin
        case (req_field)
          2'd0: sh_cfg_d[i*CFGW +: CFGW]    = req_wdata[CFGW-1:0];
          2'd1: sh_tech_d[i*TECHW +: TECHW] = req_wdata[TECHW-1:0];
          2'd2: begin
            sh_ie_d[i]  = req_wdata[1];
            sh_oen_d[i] = req_wdata[0];
          end
          default: sh_ie_d[i] = sh_ie_q[i];
        endcase
      end else begin
        sh_ie_d[i] = sh_ie_q[i];
      end
    end
  end

  // Sequencer state, settle counter and handshake/busy flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Response, shadow and live pad registers; reset leaves pads disabled and no partial load.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      sh_cfg_q    <= '0;
      sh_tech_q   <= '0;
      sh_ie_q     <= '0;
      sh_oen_q    <= '1;
      cfg_q       <= '0;
      tech_q      <= '0;
      ie_q        <= '0;
      oen_q       <= '1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      sh_cfg_q    <= sh_cfg_d;
      sh_tech_q   <= sh_tech_d;
      sh_ie_q     <= sh_ie_d;
      sh_oen_q    <= sh_oen_d;
      cfg_q       <= cfg_d;
      tech_q      <= tech_d;
      ie_q        <= ie_d;
      oen_q       <= oen_d;
    end
  end

  assign req_ready    = ready_q & ~commit;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign pad_cfg      = cfg_q;
  assign pad_tech_cfg = tech_q;
  assign pad_ie       = ie_q;
  assign pad_oen      = oen_q;

endmodule
